// File: rtl/btn_conditioner_pkg.sv
// Shared reset-FSM encodings and counter-width helper for the button conditioner.
package btn_pkg;

  localparam logic [1:0] RST_IDLE   = 2'd0;
  localparam logic [1:0] RST_ASSERT = 2'd1;
  localparam logic [1:0] RST_HOLD   = 2'd2;

  // Width of a counter that must be able to hold the value n.
  function automatic int cntWidth(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Board-side button/CPU signal bundle for btn_conditioner.
interface btn_conditioner_if;

  logic btn_rst;
  logic btn_intr;
  logic intr_ack;
  logic cpu_rst;
  logic intr_req;
  logic btn_rst_db;
  logic btn_intr_db;

  modport master (
    output btn_rst, btn_intr, intr_ack,
    input  cpu_rst, intr_req, btn_rst_db, btn_intr_db
  );

  modport slave (
    input  btn_rst, btn_intr, intr_ack,
    output cpu_rst, intr_req, btn_rst_db, btn_intr_db
  );

endinterface

// File: rtl/btn_conditioner_debounce.sv
// btn_debounce: 2-flop synchroniser, stable-count debounce, registered level and rise strobe.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);
  import btn_pkg::*;

  localparam int CW = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic sync1_q, sync2_q;
  logic level_q, level_d;
  logic levelDly_q;
  logic [CW-1:0] count_q, count_d;

  // Any disagreement that does not persist long enough restarts the count.
  always_comb begin
    level_d = level_q;
    count_d = '0;
    if (sync2_q != level_q) begin
      if (count_q == LAST) begin
        level_d = sync2_q;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      levelDly_q <= 1'b0;
      count_q    <= '0;
    end else begin
      sync1_q    <= btn_i;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      levelDly_q <= level_q;
      count_q    <= count_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~levelDly_q;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: debounced CPU reset stretcher and latched interrupt request.
// Define BTN_INTR_QUEUE_EN to count presses that arrive while a request is pending.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RST_HOLD_CYCLES = 16
) (
  input logic         clk,
  input logic         rst,
  btn_conditioner_if.slave bus
);
  import btn_pkg::*;

  localparam int HW = cntWidth(RST_HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

  logic rstDb, rstRise;
  logic intrDb, intrRise;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uRstDb (
    .clk(clk), .rst(rst), .btn_i(bus.btn_rst), .level_o(rstDb), .rise_o(rstRise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uIntrDb (
    .clk(clk), .rst(rst), .btn_i(bus.btn_intr), .level_o(intrDb), .rise_o(intrRise)
  );

  logic intrReq_q, intrReq_d;

`ifdef BTN_INTR_QUEUE_EN
  logic [1:0] pending_q, pending_d;

  // A new press always wins; an ack retires one queued press before dropping the request.
  always_comb begin
    intrReq_d = intrReq_q;
    pending_d = pending_q;
    if (intrRise) begin
      intrReq_d = 1'b1;
      if (intrReq_q && !bus.intr_ack && pending_q != 2'd3) begin
        pending_d = pending_q + 2'd1;
      end
    end else if (bus.intr_ack && intrReq_q) begin
      if (pending_q != 2'd0) begin
        pending_d = pending_q - 2'd1;
      end else begin
        intrReq_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 2'd0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  always_comb begin
    intrReq_d = intrReq_q;
    if (intrRise) begin
      intrReq_d = 1'b1;
    end else if (bus.intr_ack) begin
      intrReq_d = 1'b0;
    end
  end
`endif

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] holdCnt_q, holdCnt_d;
  logic          cpuRst_q;

  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    case (state_q)
      RST_ASSERT: begin
        if (!rstDb) begin
          state_d   = RST_HOLD;
          holdCnt_d = '0;
        end
      end
      RST_HOLD: begin
        holdCnt_d = holdCnt_q + HW'(1);
        if (rstDb) begin
          state_d = RST_ASSERT;
        end else if (holdCnt_q == HOLD_LAST) begin
          state_d = RST_IDLE;
        end
      end
      RST_IDLE: begin
        if (rstDb) begin
          state_d = RST_ASSERT;
        end
      end
      default: begin
        state_d   = RST_HOLD;
        holdCnt_d = '0;
      end
    endcase
  end

  // cpu_rst comes from its own flop so state-encoding transitions cannot glitch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_HOLD;
      holdCnt_q <= '0;
      cpuRst_q  <= 1'b1;
      intrReq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
      cpuRst_q  <= (state_d != RST_IDLE);
      intrReq_q <= intrReq_d;
    end
  end

  assign bus.cpu_rst     = cpuRst_q;
  assign bus.intr_req    = intrReq_q;
  assign bus.btn_rst_db  = rstDb;
  assign bus.btn_intr_db = intrDb;

  logic unusedRise;
  assign unusedRise = rstRise;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner with DEBOUNCE_CYCLES=8, RST_HOLD_CYCLES=4.
module tb_btn_conditioner;

  logic clk;
  logic rst;
  int   checkCount;
  int   errCount;

  btn_conditioner_if bus ();

  btn_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .RST_HOLD_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepClock(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input int got, input int exp);
    checkCount++;
    if (got != exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    checkCount   = 0;
    errCount     = 0;
    rst          = 1'b1;
    bus.btn_rst  = 1'b0;
    bus.btn_intr = 1'b0;
    bus.intr_ack = 1'b0;

    // Power-up stretch
    stepClock(3);
    checkOutput("rstCpuRst", bus.cpu_rst, 1);
    checkOutput("rstIntrReq", bus.intr_req, 0);
    checkOutput("rstRstDb", bus.btn_rst_db, 0);
    checkOutput("rstIntrDb", bus.btn_intr_db, 0);
    rst = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      stepClock(1);
      checkOutput("pwrCpuRst", bus.cpu_rst, (j < 4) ? 1 : 0);
      checkOutput("pwrIntrReq", bus.intr_req, 0);
    end

    // Bouncing interrupt button never reaches the debounced level
    for (int i = 0; i < 40; i++) begin
      bus.btn_intr = (((i / 3) % 2) == 0);
      stepClock(1);
      checkOutput("bounceDb", bus.btn_intr_db, 0);
    end
    bus.btn_intr = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      stepClock(1);
      checkOutput("settleDb", bus.btn_intr_db, (j >= 10) ? 1 : 0);
      checkOutput("settleReq", bus.intr_req, (j >= 11) ? 1 : 0);
    end

    // Ack clears; held button gives no second request; re-press requests again
    bus.intr_ack = 1'b1;
    stepClock(1);
    bus.intr_ack = 1'b0;
    checkOutput("ackClear", bus.intr_req, 0);
    stepClock(5);
    checkOutput("holdOnce", bus.intr_req, 0);
    bus.intr_ack = 1'b1;
    stepClock(1);
    bus.intr_ack = 1'b0;
    checkOutput("idleAck", bus.intr_req, 0);
    bus.btn_intr = 1'b0;
    stepClock(12);
    checkOutput("releaseDb", bus.btn_intr_db, 0);
    checkOutput("releaseReq", bus.intr_req, 0);
    bus.btn_intr = 1'b1;
    stepClock(10);
    checkOutput("repressDb", bus.btn_intr_db, 1);
    checkOutput("repressEarly", bus.intr_req, 0);
    stepClock(1);
    checkOutput("repressReq", bus.intr_req, 1);

    // Rise coincident with ack keeps the request
    bus.btn_intr = 1'b0;
    stepClock(12);
    bus.btn_intr = 1'b1;
    stepClock(10);
    checkOutput("riseAckPre", bus.intr_req, 1);
    bus.intr_ack = 1'b1;
    stepClock(1);
    bus.intr_ack = 1'b0;
    checkOutput("riseAck", bus.intr_req, 1);

    // Three more presses while pending, then four acks
    for (int p = 0; p < 3; p++) begin
      bus.btn_intr = 1'b0;
      stepClock(12);
      bus.btn_intr = 1'b1;
      stepClock(12);
      checkOutput("extraPress", bus.intr_req, 1);
    end
    for (int n = 1; n <= 4; n++) begin
      bus.intr_ack = 1'b1;
      stepClock(1);
      bus.intr_ack = 1'b0;
      stepClock(1);
`ifdef BTN_INTR_QUEUE_EN
      checkOutput("queueAck", bus.intr_req, (n < 4) ? 1 : 0);
`else
      checkOutput("mergeAck", bus.intr_req, 0);
`endif
    end

    // Reset button: press, brief raw release, final release with hold stretch
    bus.btn_rst = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      stepClock(1);
      checkOutput("rstPressDb", bus.btn_rst_db, (j >= 10) ? 1 : 0);
      checkOutput("rstPressCpu", bus.cpu_rst, (j >= 11) ? 1 : 0);
    end
    bus.btn_rst = 1'b0;
    stepClock(2);
    checkOutput("rstBlipCpu", bus.cpu_rst, 1);
    bus.btn_rst = 1'b1;
    for (int j = 1; j <= 15; j++) begin
      stepClock(1);
      checkOutput("rstRepressCpu", bus.cpu_rst, 1);
      checkOutput("rstRepressDb", bus.btn_rst_db, 1);
    end
    bus.btn_rst = 1'b0;
    for (int j = 1; j <= 17; j++) begin
      stepClock(1);
      checkOutput("rstRelDb", bus.btn_rst_db, (j < 10) ? 1 : 0);
      checkOutput("rstRelCpu", bus.cpu_rst, (j < 15) ? 1 : 0);
    end
    checkOutput("rstNoIntr", bus.intr_req, 0);

    // Block reset mid-debounce restarts the count
    bus.btn_intr = 1'b0;
    stepClock(12);
    checkOutput("midPreReq", bus.intr_req, 0);
    bus.btn_intr = 1'b1;
    stepClock(7);
    rst = 1'b1;
    stepClock(1);
    rst = 1'b0;
    checkOutput("midRstDb", bus.btn_intr_db, 0);
    checkOutput("midRstCpu", bus.cpu_rst, 1);
    checkOutput("midRstReq", bus.intr_req, 0);
    for (int j = 1; j <= 12; j++) begin
      stepClock(1);
      checkOutput("postRstDb", bus.btn_intr_db, (j >= 10) ? 1 : 0);
      checkOutput("postRstReq", bus.intr_req, (j >= 11) ? 1 : 0);
      checkOutput("postRstCpu", bus.cpu_rst, (j < 4) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", checkCount, errCount);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end input stage that feeds the board I/O block.
- Takes the raw push-buttons (CPU reset button, external-interrupt button) and does three things for each: 2-flop synchronisation, counter-based debounce, and edge detection.
- Produces a stretched CPU reset pulse, plus a level interrupt request that is held until the CPU acknowledges it.
- Replaces ad-hoc raw-button use, so the CPU never sees bounce or metastable edges.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronised cycles needed to accept a new button level (10 ms at 100 MHz); counter width = $clog2(DEBOUNCE_CYCLES+1).
- RST_HOLD_CYCLES, 16: cycles cpu_rst stays high after the debounced reset button is released, or after block reset.

Ports:
- clk  input  1  board clock
- rst  input  1  synchronous active-high reset
- btn_rst  input  1  raw CPU-reset button, active-high, asynchronous to clk
- btn_intr  input  1  raw external-interrupt button, active-high, asynchronous
- intr_ack  input  1  one-cycle acknowledge from the CPU interrupt logic
- cpu_rst  output  1  active-high CPU reset, glitch-free, registered
- intr_req  output  1  external interrupt request level, registered
- btn_rst_db  output  1  debounced reset-button level (for LEDs)
- btn_intr_db  output  1  debounced interrupt-button level

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high; everything is sampled on the rising edge of clk.
- Reset values:
  - sync flops 0; debounced levels 0; debounce counters 0
  - intr_req 0
  - cpu_rst 1; reset FSM in HOLD with hold counter 0 (power-on reset stretch)
- Synchroniser: s1 <= btn, s2 <= s1, per button. Only s2 is used downstream.
- Debounce, per button:
  - If s2 == db: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: db <= s2, counter <= 0.
  - Else: counter++.
  - Any bounce resets the count, so glitches shorter than DEBOUNCE_CYCLES never propagate.
- Latency: btn first sampled high at edge k, then held high.
  - btn_*_db rises at edge k+1+DEBOUNCE_CYCLES.
  - intr_req rises at edge k+2+DEBOUNCE_CYCLES.
  - Release is symmetric.
- Interrupt request:
  - rise = btn_intr_db & ~btn_intr_db_q.
  - Next-state priority: rise -> 1; else intr_ack -> 0; else hold.
  - rise and intr_ack in the same cycle: intr_req stays 1; the new press wins and the ack is consumed by the old request.
  - intr_ack while intr_req=0: ignored.
  - A second rise while intr_req=1 is merged (lost) unless the optional feature is enabled.
  - Holding the button generates exactly one request.
- Reset FSM (2 bits):
  - ASSERT: cpu_rst=1 while btn_rst_db=1; on btn_rst_db=0 -> HOLD, hold counter <= 0.
  - HOLD: cpu_rst=1; counter++; btn_rst_db=1 -> ASSERT; when counter == RST_HOLD_CYCLES-1 -> IDLE.
  - IDLE: cpu_rst=0; btn_rst_db=1 -> ASSERT (cpu_rst high the next cycle).
  - Unused encoding -> HOLD.
- cpu_rst does not clear intr_req. Clearing it is the CPU's responsibility via intr_ack.
- rst mid-operation: all state returns to the reset values on the next edge, even mid-debounce or mid-hold.

Optional Feature:
- Macro: BTN_INTR_QUEUE_EN.
- Defined:
  - A 2-bit saturating pending counter records rises that arrive while intr_req=1 (saturates at 3).
  - On intr_ack with pending>0: intr_req stays 1 and pending decrements.
  - rise+ack together: pending unchanged, intr_req stays 1.
- Undefined: the merge behaviour above; no counter is synthesised.

Decomposition:
- Package btn_pkg: reset FSM state enum (RST_IDLE, RST_ASSERT, RST_HOLD), plus a localparam helper for counter width.
- Natural sub-module: btn_debounce (synchroniser + debounce counter + registered level + rise strobe), parameterised by DEBOUNCE_CYCLES.
  - Instantiated twice.
  - The top of btn_conditioner holds the interrupt latch and the reset FSM.

Test Plan (DEBOUNCE_CYCLES=8, RST_HOLD_CYCLES=4):
- Power-up: rst high 3 cycles then low -> cpu_rst=1 for exactly 4 more cycles then 0; intr_req=0 throughout.
- btn_intr toggles every 3 cycles for 40 cycles then settles high -> btn_intr_db never changes during the toggling; intr_req rises at edge k+10 after the first stable-high sample, exactly once.
- intr_req=1, pulse intr_ack 1 cycle -> intr_req=0 next edge; press again (debounced) -> intr_req=1 again.
- Debounced rise coincident with intr_ack -> intr_req stays 1; with BTN_INTR_QUEUE_EN, 3 extra presses while pending then 4 acks -> intr_req drops only after the 4th ack.
- btn_rst held 20 cycles, released, re-pressed at hold cycle 2 -> cpu_rst stays continuously high; after the final release, exactly 4 hold cycles before 0.
- rst asserted mid-debounce (counter=5) -> counter 0, db 0, cpu_rst 1 on the next edge; no spurious intr_req.
